// File: rtl/pong_game_state.sv
// Frame-rate pong engine: paddles, ball, scores and serve/point flow.
// Define PONG_P2_AI_EN to let P2 track the ball instead of p2_up/p2_down.
module pong_game_state #(
    parameter int WIDTH         = 640,
    parameter int HEIGHT        = 480,
    parameter int PADDLE_WIDTH  = 4,
    parameter int PADDLE_HEIGHT = 20,
    parameter int BALL_SIZE     = 2,
    parameter int PADDLE_SPEED  = 4,
    parameter int BALL_SPEED    = 2,
    parameter int WIN_SCORE     = 9,
    parameter int POINT_HOLD    = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       p1_up,
    input  logic       p1_down,
    input  logic       p2_up,
    input  logic       p2_down,
    input  logic       serve,
    output logic [9:0] p1_paddle_pos,
    output logic [9:0] p2_paddle_pos,
    output logic [9:0] ball_x_pos,
    output logic [9:0] ball_y_pos,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic       game_over
);
    localparam int HW = $clog2(POINT_HOLD);

    localparam logic [9:0] H_V     = 10'(HEIGHT);
    localparam logic [9:0] W_V     = 10'(WIDTH);
    localparam logic [9:0] PW_V    = 10'(PADDLE_WIDTH);
    localparam logic [9:0] PH_V    = 10'(PADDLE_HEIGHT);
    localparam logic [9:0] BS_V    = 10'(BALL_SIZE);
    localparam logic [9:0] PS_V    = 10'(PADDLE_SPEED);
    localparam logic [9:0] BV_V    = 10'(BALL_SPEED);
    localparam logic [9:0] PMAX_V  = 10'(HEIGHT - 1 - PADDLE_HEIGHT);
    localparam logic [9:0] PAD_RST = 10'((HEIGHT - PADDLE_HEIGHT) / 2);
    localparam logic [9:0] BX_RST  = 10'(WIDTH / 2 - BALL_SIZE / 2);
    localparam logic [9:0] BY_RST  = 10'(HEIGHT / 2 - BALL_SIZE / 2);
    localparam logic [3:0] WIN_V   = 4'(WIN_SCORE);
    localparam logic [HW-1:0] HOLD_LAST = HW'(POINT_HOLD - 1);

    typedef enum logic [1:0] {
        S_SERVE,
        S_PLAY,
        S_SCORED,
        S_OVER
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    p1_q, p1_d, p2_q, p2_d;
    logic [9:0]    bx_q, bx_d, by_q, by_d;
    logic [3:0]    s1_q, s1_d, s2_q, s2_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          dx_q, dx_d;
    logic          dy_q, dy_d;
    logic          sdir_q, sdir_d;
    logic          go_q, go_d;

    logic hit1, hit2;
    logic p2_mv_up, p2_mv_dn;

    // Bounds are checked before stepping so the 10-bit position never wraps.
    function automatic logic [9:0] pad_step(input logic [9:0] pos,
                                            input logic up,
                                            input logic dn);
        logic [9:0] r;
        r = pos;
        if (up && !dn)
            r = (pos < PS_V) ? '0 : pos - PS_V;
        else if (dn && !up)
            r = (pos > PMAX_V - PS_V) ? PMAX_V : pos + PS_V;
        return r;
    endfunction

    assign hit1 = (by_q + BS_V > p1_q) && (by_q <= p1_q + PH_V);
    assign hit2 = (by_q + BS_V > p2_q) && (by_q <= p2_q + PH_V);

`ifdef PONG_P2_AI_EN
    logic unused_p2_keys;
    assign unused_p2_keys = p2_up ^ p2_down;
    assign p2_mv_up = (by_q + BS_V / 2 + PS_V) < (p2_q + PH_V / 2);
    assign p2_mv_dn = (by_q + BS_V / 2) > (p2_q + PH_V / 2 + PS_V);
`else
    assign p2_mv_up = p2_up;
    assign p2_mv_dn = p2_down;
`endif

    always_comb begin
        state_d = state_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        bx_d    = bx_q;
        by_d    = by_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        hold_d  = hold_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        sdir_d  = sdir_q;
        go_d    = go_q;
        if (frame_tick) begin
            if (state_q != S_OVER) begin
                p1_d = pad_step(p1_q, p1_up, p1_down);
                p2_d = pad_step(p2_q, p2_mv_up, p2_mv_dn);
            end
            unique case (state_q)
                S_SERVE: begin
                    if (serve) begin
                        state_d = S_PLAY;
                        dx_d    = sdir_q;
                    end
                end
                S_PLAY: begin
                    by_d = dy_q ? by_q + BV_V : by_q - BV_V;
                    if (!dy_q && by_q <= BV_V) begin
                        by_d = '0;
                        dy_d = 1'b1;
                    end else if (dy_q && by_q + BS_V + BV_V >= H_V) begin
                        by_d = H_V - BS_V;
                        dy_d = 1'b0;
                    end
                    bx_d = dx_q ? bx_q + BV_V : bx_q - BV_V;
                    // Paddle hit tests use the paddle positions before this frame.
                    if (!dx_q && bx_q <= PW_V + BV_V) begin
                        if (hit1) begin
                            bx_d = PW_V + 10'd1;
                            dx_d = 1'b1;
                        end else begin
                            s2_d    = (s2_q == WIN_V) ? s2_q : s2_q + 4'd1;
                            sdir_d  = 1'b0;
                            bx_d    = BX_RST;
                            by_d    = BY_RST;
                            state_d = S_SCORED;
                        end
                    end else if (dx_q && bx_q + BS_V + BV_V >= W_V - PW_V) begin
                        if (hit2) begin
                            bx_d = W_V - PW_V - BS_V - 10'd1;
                            dx_d = 1'b0;
                        end else begin
                            s1_d    = (s1_q == WIN_V) ? s1_q : s1_q + 4'd1;
                            sdir_d  = 1'b1;
                            bx_d    = BX_RST;
                            by_d    = BY_RST;
                            state_d = S_SCORED;
                        end
                    end
                end
                S_SCORED: begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d = '0;
                        if (s1_q == WIN_V || s2_q == WIN_V) begin
                            state_d = S_OVER;
                            go_d    = 1'b1;
                        end else begin
                            state_d = S_SERVE;
                        end
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
                S_OVER: begin
                    if (serve) begin
                        s1_d    = '0;
                        s2_d    = '0;
                        p1_d    = PAD_RST;
                        p2_d    = PAD_RST;
                        bx_d    = BX_RST;
                        by_d    = BY_RST;
                        sdir_d  = 1'b1;
                        go_d    = 1'b0;
                        state_d = S_SERVE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_SERVE;
            p1_q    <= PAD_RST;
            p2_q    <= PAD_RST;
            bx_q    <= BX_RST;
            by_q    <= BY_RST;
            s1_q    <= '0;
            s2_q    <= '0;
            hold_q  <= '0;
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            sdir_q  <= 1'b1;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            hold_q  <= hold_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            sdir_q  <= sdir_d;
            go_q    <= go_d;
        end
    end

    assign p1_paddle_pos = p1_q;
    assign p2_paddle_pos = p2_q;
    assign ball_x_pos    = bx_q;
    assign ball_y_pos    = by_q;
    assign p1_score      = s1_q;
    assign p2_score      = s2_q;
    assign game_over     = go_q;
endmodule

// File: tb/tb_pong_game_state.sv
// Randomized bench for pong_game_state against an integer game model.
// Directed openings cover reset, paddle clamp, serve and a right-edge miss.
module tb_pong_game_state;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0;
    logic       p1_up = 1'b0, p1_down = 1'b0;
    logic       p2_up = 1'b0, p2_down = 1'b0;
    logic       serve = 1'b0;
    logic [9:0] p1_paddle_pos, p2_paddle_pos, ball_x_pos, ball_y_pos;
    logic [3:0] p1_score, p2_score;
    logic       game_over;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pong_game_state dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .p1_up(p1_up), .p1_down(p1_down),
        .p2_up(p2_up), .p2_down(p2_down),
        .serve(serve),
        .p1_paddle_pos(p1_paddle_pos), .p2_paddle_pos(p2_paddle_pos),
        .ball_x_pos(ball_x_pos), .ball_y_pos(ball_y_pos),
        .p1_score(p1_score), .p2_score(p2_score),
        .game_over(game_over)
    );

    // Game model: signed velocities, plain integer geometry.
    localparam int M_SERVE = 0, M_PLAY = 1, M_SCORED = 2, M_OVER = 3;
    int m_st, m_p1, m_p2, m_bx, m_by, m_vx, m_vy;
    int m_s1, m_s2, m_hold, m_srv;
    int m_hits1, m_tops;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pad(input int p, input bit u, input bit d);
        if (u && !d) return (p < 4) ? 0 : p - 4;
        if (d && !u) return (p + 4 > 459) ? 459 : p + 4;
        return p;
    endfunction

    function automatic void m_reset();
        m_st = M_SERVE; m_p1 = 230; m_p2 = 230;
        m_bx = 319; m_by = 239; m_vx = 2; m_vy = 2;
        m_s1 = 0; m_s2 = 0; m_hold = 0; m_srv = 2;
    endfunction

    function automatic void m_frame(input bit u1, input bit d1,
                                    input bit u2, input bit d2, input bit sv);
        int o1, o2, nx, ny;
        o1 = m_p1; o2 = m_p2;
        if (m_st != M_OVER) begin
            m_p1 = pad(m_p1, u1, d1);
`ifdef PONG_P2_AI_EN
            if (m_by + 1 + 4 < m_p2 + 10) m_p2 = pad(m_p2, 1, 0);
            else if (m_by + 1 > m_p2 + 10 + 4) m_p2 = pad(m_p2, 0, 1);
`else
            m_p2 = pad(m_p2, u2, d2);
`endif
        end
        case (m_st)
            M_SERVE: if (sv) begin m_st = M_PLAY; m_vx = m_srv; end
            M_PLAY: begin
                ny = m_by + m_vy;
                if (m_vy < 0 && m_by <= 2) begin ny = 0; m_vy = 2; m_tops++; end
                else if (m_vy > 0 && m_by + 4 >= 480) begin ny = 478; m_vy = -2; end
                nx = m_bx + m_vx;
                if (m_vx < 0 && m_bx <= 6) begin
                    if (m_by + 2 > o1 && m_by <= o1 + 20) begin
                        nx = 5; m_vx = 2; m_hits1++;
                    end else begin
                        m_s2 = (m_s2 < 9) ? m_s2 + 1 : 9;
                        m_srv = -2; nx = 319; ny = 239; m_st = M_SCORED;
                    end
                end else if (m_vx > 0 && m_bx + 4 >= 636) begin
                    if (m_by + 2 > o2 && m_by <= o2 + 20) begin
                        nx = 633; m_vx = -2;
                    end else begin
                        m_s1 = (m_s1 < 9) ? m_s1 + 1 : 9;
                        m_srv = 2; nx = 319; ny = 239; m_st = M_SCORED;
                    end
                end
                m_bx = nx; m_by = ny;
            end
            M_SCORED: begin
                if (m_hold == 59) begin
                    m_hold = 0;
                    m_st = (m_s1 == 9 || m_s2 == 9) ? M_OVER : M_SERVE;
                end else m_hold++;
            end
            default: if (sv) begin
                m_s1 = 0; m_s2 = 0; m_p1 = 230; m_p2 = 230;
                m_bx = 319; m_by = 239; m_srv = 2; m_st = M_SERVE;
            end
        endcase
    endfunction

    task automatic cmp_all();
        chk("p1_pos", int'(p1_paddle_pos), m_p1);
        chk("p2_pos", int'(p2_paddle_pos), m_p2);
        chk("ball_x", int'(ball_x_pos), m_bx);
        chk("ball_y", int'(ball_y_pos), m_by);
        chk("p1_score", int'(p1_score), m_s1);
        chk("p2_score", int'(p2_score), m_s2);
        chk("game_over", int'(game_over), int'(m_st == M_OVER));
    endtask

    task automatic step(input bit r, input bit t, input bit u1, input bit d1,
                        input bit u2, input bit d2, input bit sv);
        rst = r; frame_tick = t;
        p1_up = u1; p1_down = d1; p2_up = u2; p2_down = d2; serve = sv;
        @(posedge clk);
        if (r) m_reset();
        else if (t) m_frame(u1, d1, u2, d2, sv);
        #1;
        cmp_all();
    endtask

    int  go_seen = 0;
    bit  tr1, tr2, u1, d1, u2, d2;
    int  waited;

    initial begin
        m_reset();
        m_hits1 = 0; m_tops = 0;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0);
        chk("rst_p1", int'(p1_paddle_pos), 230);
        chk("rst_bx", int'(ball_x_pos), 319);
        chk("rst_by", int'(ball_y_pos), 239);

        for (int i = 0; i < 60; i++) step(0, 1, 1, 0, 0, 0, 0);
        chk("p1_clamp_top", int'(p1_paddle_pos), 0);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 1, 0, 0, 0);
        chk("p1_both_hold", int'(p1_paddle_pos), 0);

        step(0, 1, 0, 0, 1, 0, 1);
        step(0, 1, 0, 0, 1, 0, 0);
        chk("serve_bx", int'(ball_x_pos), 321);
        chk("serve_by", int'(ball_y_pos), 241);

        waited = 0;
        while (m_st == M_PLAY && waited < 400) begin
            step(0, 1, 0, 0, 1, 0, 0);
            waited++;
        end
        chk("miss_in_time", int'(waited < 400), 1);
        chk("miss_p1_score", int'(p1_score), 1);
        chk("miss_bx", int'(ball_x_pos), 319);
        for (int i = 0; i < 59; i++) step(0, 1, 0, 0, 0, 0, 1);
        chk("hold_still_scored", m_st, M_SCORED);
        step(0, 1, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0);
        chk("reserve_right", int'(ball_x_pos), 321);

        for (int c = 0; c < 40000; c++) begin
            if (c % 256 == 0) begin
                tr1 = ($urandom_range(0, 2) == 0);
                tr2 = ($urandom_range(0, 2) == 0);
            end
            u1 = tr1 ? (m_by + 1 < m_p1 + 10) : bit'($urandom_range(0, 1));
            d1 = tr1 ? (m_by + 1 > m_p1 + 10) : bit'($urandom_range(0, 1));
            u2 = tr2 ? (m_by + 1 < m_p2 + 10) : bit'($urandom_range(0, 1));
            d2 = tr2 ? (m_by + 1 > m_p2 + 10) : bit'($urandom_range(0, 1));
            step(bit'($urandom_range(0, 9999) == 0),
                 bit'($urandom_range(0, 3) != 0),
                 u1, d1, u2, d2,
                 bit'($urandom_range(0, 7) == 0));
            if (game_over) go_seen++;
        end
        chk("game_over_seen", int'(go_seen > 0), 1);
        chk("p1_hits_seen", int'(m_hits1 > 0), 1);
        chk("top_bounce_seen", int'(m_tops > 0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
